// File: rtl/tia_horizontal_motion.sv
// TIA horizontal motion: HM registers plus the HMOVE sequencer that emits extra clocks per object.
// Optional macro TIA_HMOVE_BLANK_EN adds the hmove_blank output.
module tia_horizontal_motion #(
  parameter logic [3:0] COUNT_START = 4'd15
) (
  input  logic              clkp,
  input  logic              reset,
  input  logic              h1,
  input  logic              hmove,
  input  logic              hmclr,
  input  logic [4:0]        hm_wr,
  input  logic signed [3:0] d,
  output logic              sec,
  output logic [4:0]        mec_bar,
`ifdef TIA_HMOVE_BLANK_EN
  output logic              hmove_blank,
`endif
  output logic signed [3:0] hm_p0,
  output logic signed [3:0] hm_p1,
  output logic signed [3:0] hm_m0,
  output logic signed [3:0] hm_m1,
  output logic signed [3:0] hm_bl
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [4:0]        flags_q, flags_d;
  logic signed [3:0] hm_q [5];

  logic              start, run_tick, end_tick, active_tick;
  logic [3:0]        tick_cnt;
  logic [4:0]        tick_flags, hit, pulse;

  // An object stops receiving extra clocks when the counter reaches its motion value with bits 2:0 inverted.
  function automatic logic [3:0] stop_code(input logic signed [3:0] hm);
    return $unsigned(hm) ^ 4'b0111;
  endfunction

  always_ff @(posedge clkp or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) hm_q[i] <= '0;
    end else if (hmclr) begin
      for (int i = 0; i < 5; i++) hm_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++)
        if (hm_wr[i]) hm_q[i] <= d;
    end
  end

  always_ff @(posedge clkp or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
    end
  end

  // cnt_q holds the value used at the most recent tick; the next tick uses one less.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    flags_d     = flags_q;
    hit         = '0;
    start       = h1 & (pending_q | hmove);
    run_tick    = h1 & ~start & (state_q == RUN) & (cnt_q != 4'd0);
    end_tick    = h1 & ~start & (state_q == RUN) & (cnt_q == 4'd0);
    active_tick = start | run_tick;
    tick_cnt    = start ? COUNT_START : cnt_q - 4'd1;
    tick_flags  = start ? 5'b11111 : flags_q;
    for (int i = 0; i < 5; i++) hit[i] = (tick_cnt == stop_code(hm_q[i]));
    pulse       = active_tick ? (tick_flags & ~hit) : 5'b00000;

    if (start)      pending_d = 1'b0;
    else if (hmove) pending_d = 1'b1;

    if (active_tick) begin
      state_d = RUN;
      cnt_d   = tick_cnt;
      flags_d = tick_flags & ~hit;
    end else if (end_tick) begin
      state_d = IDLE;
      cnt_d   = '0;
      flags_d = '0;
    end
  end

  assign mec_bar = reset ? 5'b11111 : ~pulse;
  assign sec     = ~reset & (start | ((state_q == RUN) & ~end_tick));

`ifdef TIA_HMOVE_BLANK_EN
  logic [3:0] blank_cnt;
  assign blank_cnt   = active_tick ? tick_cnt : cnt_q;
  assign hmove_blank = sec & (blank_cnt >= 4'd14);
`endif

  assign hm_p0 = hm_q[0];
  assign hm_p1 = hm_q[1];
  assign hm_m0 = hm_q[2];
  assign hm_m1 = hm_q[3];
  assign hm_bl = hm_q[4];

endmodule
